// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter sharing one register-file write port, with a small FIFO per requester.
// Optional macro REGFILE_ZERO_REG_EN suppresses the write strobe for entries addressed to register 0.
module regfile_write_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [DATA_W-1:0] writedata,
    output logic              grant_id,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        elig;
    logic [ADDR_W-1:0] in_addr   [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [ADDR_W-1:0] head_addr [2];
    logic [DATA_W-1:0] head_data [2];

    logic              grant_any;
    logic              grant_sel;
    logic              last_grant_reg;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;
    assign req0_ready = in_ready[0];
    assign req1_ready = in_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
            logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  cnt_reg;

            // Readiness looks at the count only, so a full FIFO never passes through in the pop cycle.
            assign in_ready[gi]  = (cnt_reg < CNT_W'(FIFO_DEPTH)) && !reset;
            assign push[gi]      = in_valid[gi] && in_ready[gi];
            assign elig[gi]      = (cnt_reg != '0);
            assign head_addr[gi] = addr_mem[rd_ptr_reg];
            assign head_data[gi] = data_mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    addr_mem[wr_ptr_reg] <= in_addr[gi];
                    data_mem[wr_ptr_reg] <= in_data[gi];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    cnt_reg <= cnt_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
                end
            end
        end
    endgenerate

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_any = |elig;
        grant_sel = 1'b0;
        if (elig[0] && elig[1]) begin
            grant_sel = ~last_grant_reg;
        end else if (elig[1]) begin
            grant_sel = 1'b1;
        end
    end

    assign pop = {grant_any & grant_sel, grant_any & ~grant_sel};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            writeaddr      <= '0;
            writedata      <= '0;
            grant_id       <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (grant_any) begin
`ifdef REGFILE_ZERO_REG_EN
            RegWrite       <= (head_addr[grant_sel] != '0);
`else
            RegWrite       <= 1'b1;
`endif
            writeaddr      <= head_addr[grant_sel];
            writedata      <= head_data[grant_sel];
            grant_id       <= grant_sel;
            last_grant_reg <= grant_sel;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    assign busy = elig[0] || elig[1] || RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter: a queue-level reference model feeds a scoreboard
// that a separate monitor drains whenever the write port strobes.
module tb_regfile_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              gid;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] writeaddr;
    logic [DATA_W-1:0] writedata;
    logic              grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;

    // Reference model state: FIFO contents as queues plus the expected write-port registers.
    ent_t              mq0[$];
    ent_t              mq1[$];
    wr_t               exp_q[$];
    logic              m_last = 1'b1;
    logic              exp_rw = 1'b0;
    logic [ADDR_W-1:0] exp_wa = '0;
    logic [DATA_W-1:0] exp_wd = '0;
    logic              exp_gid = 1'b0;

    // Stimulus state owned by the main process.
    ent_t stim0[$];
    ent_t stim1[$];
    bit   hold0 = 0;
    bit   hold1 = 0;
    bit   rnd_mode = 0;

    regfile_write_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .RegWrite  (RegWrite),
        .writeaddr (writeaddr),
        .writedata (writedata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration from queue occupancy before the edge, then pushes.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq0.delete();
                mq1.delete();
                exp_q.delete();
                m_last  = 1'b1;
                exp_rw  = 1'b0;
                exp_wa  = '0;
                exp_wd  = '0;
                exp_gid = 1'b0;
            end else begin
                bit   r0, r1, e0, e1, g;
                ent_t e;
                r0 = mq0.size() < DEPTH;
                r1 = mq1.size() < DEPTH;
                e0 = mq0.size() > 0;
                e1 = mq1.size() > 0;
                if (e0 || e1) begin
                    g = (e0 && e1) ? !m_last : e1;
                    if (g) e = mq1.pop_front();
                    else   e = mq0.pop_front();
                    m_last  = g;
                    exp_wa  = e.addr;
                    exp_wd  = e.data;
                    exp_gid = g;
                    exp_rw  = !(ZERO_EN && e.addr == '0);
                    if (exp_rw) exp_q.push_back('{e.addr, e.data, g});
                end else begin
                    exp_rw = 1'b0;
                end
                if (req0_valid && r0) mq0.push_back('{req0_addr, req0_data});
                if (req1_valid && r1) mq1.push_back('{req1_addr, req1_data});
            end
        end
    end

    // Monitor: per-cycle status checks plus scoreboard pop on every write strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                wr_t w;
                check("req0_ready", req0_ready, mq0.size() < DEPTH);
                check("req1_ready", req1_ready, mq1.size() < DEPTH);
                check("busy", busy, (mq0.size() != 0) || (mq1.size() != 0) || exp_rw);
                check("RegWrite", RegWrite, exp_rw);
                check("writeaddr_reg", writeaddr, exp_wa);
                check("writedata_reg", writedata, exp_wd);
                check("grant_id_reg", grant_id, exp_gid);
                if (RegWrite) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("sb_addr", writeaddr, w.addr);
                        check("sb_data", writedata, w.data);
                        check("sb_gid", grant_id, w.gid);
                    end
                end
            end
        end
    end

    // One stimulus cycle: present inputs at negedge, retire accepted entries after the edge.
    task automatic drive_cycle();
        bit v0, v1, a0, a1;
        @(negedge clk);
        v0 = hold0;
        v1 = hold1;
        if (!hold0) v0 = (stim0.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
        if (!hold1) v1 = (stim1.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
        req0_valid = v0;
        req1_valid = v1;
        if (v0) begin req0_addr = stim0[0].addr; req0_data = stim0[0].data; end
        if (v1) begin req1_addr = stim1[0].addr; req1_data = stim1[0].data; end
        a0 = v0 && req0_ready;
        a1 = v1 && req1_ready;
        hold0 = v0 && !a0;
        hold1 = v1 && !a1;
        @(posedge clk);
        if (a0 && stim0.size() > 0) void'(stim0.pop_front());
        if (a1 && stim1.size() > 0) void'(stim1.pop_front());
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((stim0.size() != 0 || stim1.size() != 0 || mq0.size() != 0 || mq1.size() != 0 ||
                exp_rw || exp_q.size() != 0) && n < budget) begin
            drive_cycle();
            n++;
        end
        drive_cycle();
        drive_cycle();
        check("drain_in_budget", n < budget, 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        stim0.delete();
        stim1.delete();
        hold0 = 0;
        hold1 = 0;
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_writeaddr", writeaddr, 0);
        check("rst_writedata", writedata, 0);
        check("rst_grant_id", grant_id, 0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        do_reset();

        // Single write with uncontended latency.
        stim0.push_back('{5'd5, 32'hDEADBEEF});
        wait_idle(50);

        // Tie right after reset: requester 0 first.
        do_reset();
        stim0.push_back('{5'd1, 32'd11});
        stim1.push_back('{5'd2, 32'd22});
        wait_idle(50);

        // Sustained contention, six entries each.
        for (int i = 1; i <= 6; i++) begin
            stim0.push_back('{5'(i), 32'(i)});
            stim1.push_back('{5'(i + 8), 32'(i + 100)});
        end
        wait_idle(100);

        // Backpressure: requester 1 overruns its FIFO while requester 0 competes.
        for (int i = 0; i < 4; i++) stim0.push_back('{5'(20 + i), 32'(500 + i)});
        for (int i = 0; i < 3; i++) stim1.push_back('{5'(24 + i), 32'(600 + i)});
        wait_idle(100);

        // Register-0 entry followed by a normal one on requester 0.
        stim0.push_back('{5'd0, 32'hA5A5A5A5});
        stim0.push_back('{5'd3, 32'h33});
        wait_idle(50);

        // Randomized traffic, including address 0.
        rnd_mode = 1;
        for (int i = 0; i < 60; i++) begin
            stim0.push_back('{5'($urandom_range(0, 31)), $urandom});
            stim1.push_back('{5'($urandom_range(0, 31)), $urandom});
        end
        wait_idle(600);
        rnd_mode = 0;

        // Asynchronous reset with entries pending, then one clean write.
        for (int i = 0; i < 2; i++) begin
            stim0.push_back('{5'(10 + i), 32'(900 + i)});
            stim1.push_back('{5'(12 + i), 32'(950 + i)});
        end
        drive_cycle();
        drive_cycle();
        do_reset();
        base = writes_seen;
        stim1.push_back('{5'd7, 32'd77});
        wait_idle(50);
        check("post_reset_write_count", writes_seen - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
